branch_resolve_unit: RTL
========================

# branch_resolve_unit

- Parametrised, registered branch/jump resolution stage for the RISC-V pipeline. Sits at the EX/MEM boundary.
- Evaluates the branch condition from ALU flags and computes the target.
- Compares the outcome with the fetch-time direction prediction and issues a one-cycle redirect/flush on mispredict.
- Trains a direct-mapped branch history table (BHT) of 2-bit counters and keeps a saturating mispredict count.

## Interface
Parameters:
- XLEN, 32, address/data width
- BHT_DEPTH, 64, BHT entries; power of two, ≥ 2
- CNT_W, 16, mispredict counter width

Ports:
- CLK  in  1  clock, rising edge
- RESET_N  in  1  asynchronous, active-low reset
- VALID_IN  in  1  EX-stage instruction valid
- STALL  in  1  pipeline stall; blocks resolution this cycle
- PC  in  XLEN  PC of EX instruction
- BRANCH_IMM  in  XLEN  sign-extended B-immediate
- JUMP_TARGET  in  XLEN  ALU-computed JAL/JALR target
- FUNC_3  in  3  branch funct3
- BRANCH_SIGNAL, JUMP_SIGNAL  in  1 each  instruction class
- ZERO_SIGNAL, SIGN_BIT_SIGNAL, SLTU_BIT_SIGNAL  in  1 each  rs1==rs2, rs1<rs2 signed, rs1<rs2 unsigned
- PRED_TAKEN  in  1  direction predicted at fetch for this instruction
- FETCH_PC  in  XLEN  fetch-stage PC for BHT lookup
- FETCH_PRED_TAKEN  out  1  combinational prediction for FETCH_PC
- REDIRECT_VALID  out  1  registered redirect pulse; also the flush request
- REDIRECT_PC  out  XLEN  registered redirect target
- MISPREDICT_COUNT  out  CNT_W  saturating mispredict/redirect count

## Operation
- A resolve occurs when VALID_IN=1, STALL=0, and REDIRECT_VALID=0.
  - The cycle after a redirect is the wrong-path shadow; VALID_IN is ignored in that cycle.
- Conditions:
  - beq (000): ZERO
  - bne (001): !ZERO
  - blt (100): SIGN & !ZERO
  - bge (101): !SIGN | ZERO
  - bltu (110): SLTU & !ZERO
  - bgeu (111): !SLTU | ZERO
  - 010 and 011: not taken
- taken = JUMP_SIGNAL | (BRANCH_SIGNAL & cond). JUMP_SIGNAL takes priority if both class signals are set.
- Targets, all arithmetic modulo 2^XLEN:
  - jump: JUMP_TARGET with bit 0 cleared
  - taken branch: PC + BRANCH_IMM
  - fall-through: PC + 4
- Redirect required when any of:
  - jump: always
  - branch: taken != PRED_TAKEN
- REDIRECT_PC = taken ? target : PC + 4.
- BHT:
  - Index = PC[log2(BHT_DEPTH)+1:2].
  - Counter states: SNT=00, WNT=01, WT=10, ST=11.
  - Predict taken when counter[1]=1.
  - Each resolved conditional branch updates its entry: +1 if taken, −1 if not, saturating at 00/11.
  - Jumps and non-branches do not update.
  - FETCH_PRED_TAKEN reads the old value when reading the entry being written in the same cycle.
- MISPREDICT_COUNT increments by 1 on every redirect and saturates at all-ones (no wrap).

## Timing
- Resolution latency 1 cycle: inputs sampled at edge N; REDIRECT_VALID/REDIRECT_PC valid after edge N.
- REDIRECT_VALID is a single-cycle pulse. It is never high in two consecutive cycles, because of the shadow rule.
- REDIRECT_PC holds its last value while REDIRECT_VALID=0.
- The BHT write takes effect at the same edge as the resolve.
- The stall shadow is cycle-based: a stall in the shadow cycle does not extend it.
- Reset values (asynchronous on RESET_N low):
  - REDIRECT_VALID=0, REDIRECT_PC=0, MISPREDICT_COUNT=0
  - all BHT entries=WNT, so FETCH_PRED_TAKEN=0
- Reset asserted mid-operation drops any pending redirect immediately.

## Configuration
- BRU_BHT_EN defined:
  - BHT instantiated; behaviour as above.
- BRU_BHT_EN undefined:
  - No BHT storage.
  - FETCH_PRED_TAKEN tied 0.
  - PRED_TAKEN ignored and treated as 0, giving static not-taken.
  - Every taken branch or jump redirects.
  - MISPREDICT_COUNT counts all redirects.

## Structure
- Package bru_pkg holds:
  - funct3 constants (F3_BEQ … F3_BGEU)
  - 2-bit counter state enum and reset value (WNT)
  - fall-through increment constant (4)
- Sub-module bru_bht holds:
  - counter array
  - combinational lookup port
  - saturating update port (en, idx, taken)
- bru_bht is instantiated only under BRU_BHT_EN.

## Test plan
- Reset: hold RESET_N=0 mid-stream → REDIRECT_VALID=0, MISPREDICT_COUNT=0, FETCH_PRED_TAKEN=0 for any FETCH_PC.
- beq with ZERO=1, PC=0x100, IMM=0x20, PRED_TAKEN=0 → next cycle REDIRECT_VALID=1, REDIRECT_PC=0x120, count=1.
- bne with ZERO=1, PRED_TAKEN=1, PC=0x200 → REDIRECT_PC=0x204. Same bne with PRED_TAKEN=0 → no redirect.
- JALR with JUMP_TARGET=0x3FF, VALID_IN also high in the following cycle → REDIRECT_PC=0x3FE; the shadow-cycle instruction is ignored (no second pulse, no BHT update).
- Train PC=0x40 taken 2× from reset → FETCH_PC=0x40 predicts taken. A 3rd taken resolve saturates the counter at 11, and the next not-taken resolve leaves it at 10, so the prediction stays taken.
- CNT_W=2, 5 redirects → MISPREDICT_COUNT stays at 3. PC=0xFFFFFFF0, IMM=0x20 → REDIRECT_PC=0x10 (wrap).

Source files
------------

// File: rtl/bru_pkg.sv
// Shared definitions for the branch resolve unit.
//   - branch funct3 encodings
//   - 2-bit BHT counter states, reset state and saturating update helper
//   - fall-through PC increment
package bru_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_ctr_e;

  localparam bht_ctr_e BHT_RESET = WNT;

  localparam int unsigned FALL_THROUGH_INC = 4;

  // Saturating 2-bit counter step: toward ST on taken, toward SNT otherwise.
  function automatic bht_ctr_e bht_ctr_next(input bht_ctr_e c, input logic taken);
    bht_ctr_e n;
    n = c;
    case (c)
      SNT: n = taken ? WNT : SNT;
      WNT: n = taken ? WT  : SNT;
      WT:  n = taken ? ST  : WNT;
      ST:  n = taken ? ST  : WT;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/bru_bht.sv
// Direct-mapped branch history table of 2-bit saturating counters.
// Ports:
//   CLK, RESET_N   clock (rising edge), asynchronous active-low reset
//   rd_idx_i       lookup index (fetch side)
//   rd_taken_o     combinational prediction (counter MSB) for rd_idx_i
//   upd_en_i       train the entry at upd_idx_i this cycle
//   upd_idx_i      index of the entry to train
//   upd_taken_i    resolved direction used for training
// A lookup of the entry being trained returns the pre-update value.
module bru_bht
  import bru_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned IDX_W = 6
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic             rd_taken_o,
  input  logic             upd_en_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic             upd_taken_i
);

  bht_ctr_e   ctr_q [DEPTH];
  bht_ctr_e   ctr_d;
  logic [1:0] rd_ctr;

  assign ctr_d      = bht_ctr_next(ctr_q[upd_idx_i], upd_taken_i);
  assign rd_ctr     = ctr_q[rd_idx_i];
  assign rd_taken_o = rd_ctr[1];

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ctr_q[i] <= BHT_RESET;
      end
    end else if (upd_en_i) begin
      ctr_q[upd_idx_i] <= ctr_d;
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Registered branch/jump resolution stage (EX/MEM boundary).
// Evaluates the branch condition from ALU flags, selects the target, and
// issues a one-cycle redirect (also the flush request) when the outcome
// differs from the fetch-time prediction. Counts redirects saturatingly.
// Optional feature macro: BRU_BHT_EN
//   defined   : BHT trained by resolved branches, FETCH_PRED_TAKEN from BHT
//   undefined : static not-taken; PRED_TAKEN ignored, FETCH_PRED_TAKEN = 0
// Ports:
//   CLK, RESET_N         clock (rising edge), asynchronous active-low reset
//   VALID_IN, STALL      EX instruction valid, pipeline stall
//   PC, BRANCH_IMM       EX PC and sign-extended B-immediate
//   JUMP_TARGET          ALU-computed JAL/JALR target
//   FUNC_3               branch funct3
//   BRANCH_SIGNAL        conditional branch
//   JUMP_SIGNAL          JAL/JALR (wins over BRANCH_SIGNAL)
//   ZERO/SIGN_BIT/SLTU_BIT_SIGNAL  ALU compare flags
//   PRED_TAKEN           fetch-time prediction for the EX instruction
//   FETCH_PC             fetch PC for BHT lookup
//   FETCH_PRED_TAKEN     combinational prediction for FETCH_PC
//   REDIRECT_VALID/PC    registered redirect pulse and target
//   MISPREDICT_COUNT     saturating redirect count
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned BHT_DEPTH = 64,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             VALID_IN,
  input  logic             STALL,
  input  logic [XLEN-1:0]  PC,
  input  logic [XLEN-1:0]  BRANCH_IMM,
  input  logic [XLEN-1:0]  JUMP_TARGET,
  input  logic [2:0]       FUNC_3,
  input  logic             BRANCH_SIGNAL,
  input  logic             JUMP_SIGNAL,
  input  logic             ZERO_SIGNAL,
  input  logic             SIGN_BIT_SIGNAL,
  input  logic             SLTU_BIT_SIGNAL,
  input  logic             PRED_TAKEN,
  input  logic [XLEN-1:0]  FETCH_PC,
  output logic             FETCH_PRED_TAKEN,
  output logic             REDIRECT_VALID,
  output logic [XLEN-1:0]  REDIRECT_PC,
  output logic [CNT_W-1:0] MISPREDICT_COUNT
);

  if ((BHT_DEPTH < 2) || ((BHT_DEPTH & (BHT_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("BHT_DEPTH must be a power of two >= 2");
  end

  logic             redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0] mispredict_cnt_q, mispredict_cnt_d;

  logic             resolve;
  logic             cond;
  logic             taken;
  logic             pred_eff;
  logic             redirect;
  logic [XLEN-1:0]  fall_pc;
  logic [XLEN-1:0]  branch_pc;
  logic [XLEN-1:0]  jump_pc;
  logic [XLEN-1:0]  target_pc;
  logic             unused_inputs;

  // The cycle after a redirect is the wrong-path shadow: nothing resolves.
  assign resolve = VALID_IN & ~STALL & ~redirect_valid_q;

  always_comb begin
    cond = 1'b0;
    case (FUNC_3)
      F3_BEQ:  cond = ZERO_SIGNAL;
      F3_BNE:  cond = ~ZERO_SIGNAL;
      F3_BLT:  cond = SIGN_BIT_SIGNAL & ~ZERO_SIGNAL;
      F3_BGE:  cond = ~SIGN_BIT_SIGNAL | ZERO_SIGNAL;
      F3_BLTU: cond = SLTU_BIT_SIGNAL & ~ZERO_SIGNAL;
      F3_BGEU: cond = ~SLTU_BIT_SIGNAL | ZERO_SIGNAL;
      default: cond = 1'b0;
    endcase
  end

  assign taken     = JUMP_SIGNAL | (BRANCH_SIGNAL & cond);
  assign fall_pc   = PC + XLEN'(FALL_THROUGH_INC);
  assign branch_pc = PC + BRANCH_IMM;
  assign jump_pc   = {JUMP_TARGET[XLEN-1:1], 1'b0};
  assign target_pc = JUMP_SIGNAL ? jump_pc : branch_pc;

  // Jumps always redirect; branches only when the direction was mispredicted.
  assign redirect = resolve &
                    (JUMP_SIGNAL | (BRANCH_SIGNAL & (taken != pred_eff)));

`ifdef BRU_BHT_EN
  localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

  logic bht_upd_en;

  assign pred_eff   = PRED_TAKEN;
  assign bht_upd_en = resolve & BRANCH_SIGNAL & ~JUMP_SIGNAL;

  bru_bht #(
    .DEPTH (BHT_DEPTH),
    .IDX_W (IDX_W)
  ) u_bht (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .rd_idx_i    (FETCH_PC[IDX_W+1:2]),
    .rd_taken_o  (FETCH_PRED_TAKEN),
    .upd_en_i    (bht_upd_en),
    .upd_idx_i   (PC[IDX_W+1:2]),
    .upd_taken_i (cond)
  );
`else
  assign pred_eff         = 1'b0;
  assign FETCH_PRED_TAKEN = 1'b0;
`endif

  assign unused_inputs = ^{FETCH_PC, PRED_TAKEN};

  always_comb begin
    redirect_valid_d = redirect;
    redirect_pc_d    = redirect_pc_q;
    mispredict_cnt_d = mispredict_cnt_q;
    if (redirect) begin
      redirect_pc_d = taken ? target_pc : fall_pc;
      if (mispredict_cnt_q != '1) begin
        mispredict_cnt_d = mispredict_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  assign REDIRECT_VALID   = redirect_valid_q;
  assign REDIRECT_PC      = redirect_pc_q;
  assign MISPREDICT_COUNT = mispredict_cnt_q;

endmodule
